// File: rtl/prism_cfg_sequencer.sv
// ============================================================================
// Module   : prism_cfg_sequencer
// Brief    : Bus-facing front end of the PRISM config latch loader. Captures
//            32-bit writes to the LSB/MSB config addresses and emits timed
//            debug_wr / latch_wr strobes while holding cfg_* stable.
//            Optional macro PRISM_CFG_DROP_EN: drop (and flag) writes that
//            arrive while busy instead of stalling the core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prism_cfg_sequencer #(
    parameter int          DEPTH    = 8,
    parameter logic [5:0]  ADDR_LSB = 6'h10,
    parameter logic [5:0]  ADDR_MSB = 6'h14
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    output logic        data_ready,
    output logic [5:0]  cfg_address,
    output logic [31:0] cfg_data,
    output logic        debug_wr,
    output logic        latch_wr,
    output logic        busy,
    output logic        wr_dropped
);

    localparam int                 c_CNT_W    = $clog2(2 * DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_LOAD_CNT = c_CNT_W'(2 * DEPTH);
    localparam logic [5:0]         c_NEUTRAL  = 6'h3F;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_LOAD   = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [5:0]         r_cfg_address;
    logic [31:0]        r_cfg_data;
    logic               r_debug_wr;
    logic               r_latch_wr;
    logic               w_cfg_write;
    logic               w_idle;

    assign w_cfg_write = (data_write_n == 2'b10) &&
                         ((address == ADDR_LSB) || (address == ADDR_MSB));
    assign w_idle      = (r_state == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_cfg_address <= c_NEUTRAL;
            r_cfg_data    <= '0;
            r_debug_wr    <= 1'b0;
            r_latch_wr    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cfg_write) begin
                        r_cfg_data    <= data_in;
                        r_cfg_address <= address;
                        r_state       <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    // Both sequences raise latch_wr in the strobe cycle; only LSB also pulses debug_wr.
                    r_latch_wr <= 1'b1;
                    r_debug_wr <= (r_cfg_address == ADDR_LSB);
                    r_state    <= S_STROBE;
                end
                S_STROBE: begin
                    r_debug_wr <= 1'b0;
                    if (r_cfg_address == ADDR_LSB) begin
                        r_cnt   <= c_LOAD_CNT;
                        r_state <= S_LOAD;
                    end else begin
                        r_latch_wr    <= 1'b0;
                        r_cfg_address <= c_NEUTRAL;
                        r_state       <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    if (r_cnt == '0) begin
                        r_latch_wr    <= 1'b0;
                        r_cfg_address <= c_NEUTRAL;
                        r_state       <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PRISM_CFG_DROP_EN
    logic r_wr_dropped;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_dropped <= 1'b0;
        end else if (w_cfg_write) begin
            r_wr_dropped <= !w_idle;
        end
    end

    assign data_ready = 1'b1;
    assign wr_dropped = r_wr_dropped;
`else
    // The core holds a stalled write on the bus until the first idle cycle.
    assign data_ready = w_idle || !w_cfg_write;
    assign wr_dropped = 1'b0;
`endif

    assign busy        = !w_idle;
    assign cfg_address = r_cfg_address;
    assign cfg_data    = r_cfg_data;
    assign debug_wr    = r_debug_wr;
    assign latch_wr    = r_latch_wr;

endmodule

`default_nettype wire

// File: tb/tb_prism_cfg_sequencer.sv
// ============================================================================
// Module   : tb_prism_cfg_sequencer
// Brief    : Self-checking bench for prism_cfg_sequencer; directed scenarios
//            followed by random bus traffic against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prism_cfg_sequencer;

    localparam int         DEPTH    = 8;
    localparam logic [5:0] ADDR_LSB = 6'h10;
    localparam logic [5:0] ADDR_MSB = 6'h14;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  address = 6'h00;
    logic [31:0] data_in = 32'h0;
    logic [1:0]  data_write_n = 2'b11;
    logic        data_ready;
    logic [5:0]  cfg_address;
    logic [31:0] cfg_data;
    logic        debug_wr;
    logic        latch_wr;
    logic        busy;
    logic        wr_dropped;

    int n_total = 0;
    int n_bad   = 0;

    // Model: a sequence is described only by how many cycles ago it was accepted.
    logic        m_active = 1'b0;
    logic        m_lsb    = 1'b0;
    int          m_k      = 0;
    logic [5:0]  m_addr   = 6'h3F;
    logic [31:0] m_data   = 32'h0;
    logic        m_drop   = 1'b0;

    prism_cfg_sequencer #(
        .DEPTH    (DEPTH),
        .ADDR_LSB (ADDR_LSB),
        .ADDR_MSB (ADDR_MSB)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .address      (address),
        .data_in      (data_in),
        .data_write_n (data_write_n),
        .data_ready   (data_ready),
        .cfg_address  (cfg_address),
        .cfg_data     (cfg_data),
        .debug_wr     (debug_wr),
        .latch_wr     (latch_wr),
        .busy         (busy),
        .wr_dropped   (wr_dropped)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic is_cfg_write(input logic [5:0] a, input logic [1:0] wn);
        return (wn == 2'b10) && ((a == ADDR_LSB) || (a == ADDR_MSB));
    endfunction

    function automatic int seq_len(input logic lsb);
        return lsb ? (2 + 2 * DEPTH + 1) : 2;
    endfunction

    task automatic check_outputs();
        chk("busy",        busy,        m_active);
        chk("debug_wr",    debug_wr,    m_active && m_lsb && (m_k == 2));
        chk("latch_wr",    latch_wr,    m_active && (m_k >= 2));
        chk("cfg_address", cfg_address, m_active ? m_addr : 6'h3F);
        chk("cfg_data",    cfg_data,    m_data);
        chk("wr_dropped",  wr_dropped,  m_drop);
    endtask

    task automatic model_edge();
        logic w;
        w = is_cfg_write(address, data_write_n);
        if (!m_active) begin
            if (w) begin
                m_active = 1'b1;
                m_k      = 1;
                m_lsb    = (address == ADDR_LSB);
                m_addr   = address;
                m_data   = data_in;
                m_drop   = 1'b0;
            end
        end else begin
`ifdef PRISM_CFG_DROP_EN
            if (w) m_drop = 1'b1;
`endif
            m_k++;
            if (m_k > seq_len(m_lsb)) m_active = 1'b0;
        end
    endtask

    function automatic logic exp_ready();
`ifdef PRISM_CFG_DROP_EN
        return 1'b1;
`else
        return !(m_active && is_cfg_write(address, data_write_n));
`endif
    endfunction

    // Called just after a falling edge; leaves the bench just after the next one.
    task automatic step(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn,
                        output logic accepted);
        address      = a;
        data_in      = d;
        data_write_n = wn;
        #1;
        chk("data_ready", data_ready, exp_ready());
        accepted = !m_active && is_cfg_write(a, wn);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(6'h00, 32'h0, 2'b11, acc);
    endtask

    // Keep a write on the bus the way the core would until it is taken (or dropped).
    task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
        logic acc;
        int   tries;
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 64) begin
            step(a, d, 2'b10, acc);
            tries++;
`ifdef PRISM_CFG_DROP_EN
            acc = 1'b1;
`endif
        end
        if (!acc) chk("write_timeout", 32'd0, 32'd1);
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy",     busy,        1'b0);
        chk("rst_debug_wr", debug_wr,    1'b0);
        chk("rst_latch_wr", latch_wr,    1'b0);
        chk("rst_cfg_addr", cfg_address, 6'h3F);
        chk("rst_cfg_data", cfg_data,    32'h0);
        chk("rst_ready",    data_ready,  1'b1);
        chk("rst_dropped",  wr_dropped,  1'b0);
        m_active = 1'b0;
        m_k      = 0;
        m_data   = 32'h0;
        m_drop   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs();
    endtask

    initial begin
        logic        acc;
        logic        held;
        logic [5:0]  ra;
        logic [31:0] rd;
        logic [1:0]  rwn;
        int          guard;

        @(negedge clk);
        async_reset();

        bus_write(ADDR_MSB, 32'hDEADBEEF);
        idle(3);

        bus_write(ADDR_LSB, 32'h12345678);
        idle(4);
        bus_write(ADDR_MSB, 32'hCAFEF00D);
        idle(4);

        step(ADDR_LSB, 32'hFFFF0000, 2'b00, acc);
        step(ADDR_MSB, 32'h0000FFFF, 2'b01, acc);
        idle(2);

        bus_write(ADDR_LSB, 32'hA5A5A5A5);
        guard = 0;
        while (m_active && m_k < 7 && guard < 32) begin
            idle(1);
            guard++;
        end
        async_reset();
        idle(2);

        held = 1'b0;
        ra   = 6'h00;
        rd   = 32'h0;
        rwn  = 2'b11;
        for (int c = 0; c < 800; c++) begin
            if (!held) begin
                int r;
                r = $urandom_range(0, 9);
                ra = (r < 4) ? ADDR_LSB : (r < 7) ? ADDR_MSB : 6'($urandom);
                r = $urandom_range(0, 11);
                rwn = (r < 5) ? 2'b10 : (r < 9) ? 2'b11 : (r < 10) ? 2'b00 : 2'b01;
                rd = $urandom;
            end
            step(ra, rd, rwn, acc);
`ifdef PRISM_CFG_DROP_EN
            held = 1'b0;
`else
            held = is_cfg_write(ra, rwn) && !acc;
`endif
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
